// File: rtl/gat_feature_top.sv
// gat_feature_top -- GAT feature-transform stage: WH = H x W.
// H arrives in CSR-like form (col_idx, value, node_info), W is dense. All
// arrays are captured on a single h_valid_i strobe. One nonzero is consumed
// per cycle for every output column in parallel. One WH row is emitted per node.
// Optional build macro GAT_PERF_CNT_EN adds a 16-bit saturating busy-cycle
// counter on cycle_cnt_o.
// Reset input rst_n is asynchronous and active-high despite its name.

module gat_feature_top #(
   parameter int DATA_WIDTH       = 8,
   parameter int DOT_PRODUCT_SIZE = 5,
   parameter int H_NUM_OF_COLS    = DOT_PRODUCT_SIZE,
   parameter int H_NUM_OF_ROWS    = 5,
   parameter int COL_INDEX_SIZE   = 8,
   parameter int VALUE_SIZE       = 8,
   parameter int NODE_INFO_SIZE   = H_NUM_OF_ROWS,
   parameter int W_NUM_OF_ROWS    = DOT_PRODUCT_SIZE,
   parameter int W_NUM_OF_COLS    = 3,
   parameter int COL_IDX_WIDTH    = $clog2(H_NUM_OF_COLS),
   parameter int VALUE_WIDTH      = DATA_WIDTH,
   parameter int INDEX_WIDTH      = $clog2(COL_INDEX_SIZE),
   parameter int ROW_LEN_WIDTH    = $clog2(H_NUM_OF_COLS),
   parameter int NODE_INFO_WIDTH  = INDEX_WIDTH + ROW_LEN_WIDTH + 1,
   parameter int ROW_INFO_WIDTH   = ROW_LEN_WIDTH + 1,
   parameter int WH_WIDTH         = 2*DATA_WIDTH + $clog2(DOT_PRODUCT_SIZE)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               h_valid_i,
   input  logic [COL_IDX_WIDTH-1:0]           col_idx_i   [0:COL_INDEX_SIZE-1],
   input  logic [VALUE_WIDTH-1:0]             value_i     [0:VALUE_SIZE-1],
   input  logic [NODE_INFO_WIDTH-1:0]         node_info_i [0:NODE_INFO_SIZE-1],
   input  logic [DATA_WIDTH-1:0]              weight_i    [0:W_NUM_OF_ROWS-1][0:W_NUM_OF_COLS-1],
   output logic                               wh_valid_o,
   output logic [WH_WIDTH-1:0]                wh_data_o   [0:W_NUM_OF_COLS-1],
   output logic [$clog2(H_NUM_OF_ROWS)-1:0]   wh_row_idx_o,
   output logic [ROW_INFO_WIDTH-1:0]          row_info_o,
   output logic                               busy_o,
   output logic                               done_o
`ifdef GAT_PERF_CNT_EN
   ,
   output logic [15:0]                        cycle_cnt_o
`endif
);

   localparam int ROW_IDX_WIDTH = $clog2(H_NUM_OF_ROWS);
   localparam int V_ADDR_WIDTH  = $clog2(VALUE_SIZE);
   localparam int PROD_WIDTH    = 2*DATA_WIDTH;
   // Element index idx+k can exceed the array depth; one spare bit keeps the
   // out-of-range test exact instead of wrapping.
   localparam int E_WIDTH = ((INDEX_WIDTH > ROW_LEN_WIDTH) ? INDEX_WIDTH : ROW_LEN_WIDTH) + 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] MAC    = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   logic [1:0]                 state;
   logic [ROW_IDX_WIDTH-1:0]   row;
   logic [ROW_LEN_WIDTH-1:0]   k;
   logic [WH_WIDTH-1:0]        acc        [0:W_NUM_OF_COLS-1];

   logic [COL_IDX_WIDTH-1:0]   col_idx_q  [0:COL_INDEX_SIZE-1];
   logic [VALUE_WIDTH-1:0]     value_q    [0:VALUE_SIZE-1];
   logic [NODE_INFO_WIDTH-1:0] node_info_q[0:NODE_INFO_SIZE-1];
   logic [DATA_WIDTH-1:0]      weight_q   [0:W_NUM_OF_ROWS-1][0:W_NUM_OF_COLS-1];

   logic [NODE_INFO_WIDTH-1:0] cur_info;
   logic [INDEX_WIDTH-1:0]     cur_idx;
   logic [ROW_LEN_WIDTH-1:0]   cur_len;
   logic                       cur_flag;
   logic [E_WIDTH-1:0]         elem;
   logic                       elem_ok;
   logic [COL_IDX_WIDTH-1:0]   col_sel;
   logic [VALUE_WIDTH-1:0]     val_sel;
   logic                       col_ok;
   logic                       last_elem;
   logic                       last_row;
   logic [PROD_WIDTH-1:0]      product    [0:W_NUM_OF_COLS-1];
   logic [WH_WIDTH-1:0]        acc_next   [0:W_NUM_OF_COLS-1];

   // Decode the current element and form acc + value*W[col] for every column.
   // NOTE: every signal gets a default before any conditional assignment, so no latch is inferred.
   always_comb begin
      cur_info  = node_info_q[row];
      cur_idx   = cur_info[NODE_INFO_WIDTH-1 -: INDEX_WIDTH];
      cur_len   = cur_info[ROW_LEN_WIDTH:1];
      cur_flag  = cur_info[0];
      elem      = E_WIDTH'(cur_idx) + E_WIDTH'(k);
      elem_ok   = (k < cur_len) &&
                  (elem < E_WIDTH'(COL_INDEX_SIZE)) &&
                  (elem < E_WIDTH'(VALUE_SIZE));
      col_sel   = '0;
      val_sel   = '0;
      if (elem_ok) begin
         col_sel = col_idx_q[elem[INDEX_WIDTH-1:0]];
         val_sel = value_q[elem[V_ADDR_WIDTH-1:0]];
      end
      col_ok    = elem_ok && (col_sel < COL_IDX_WIDTH'(W_NUM_OF_ROWS));
      // A zero-length row still occupies one cycle and closes immediately.
      last_elem = (cur_len == '0) || (k == cur_len - ROW_LEN_WIDTH'(1));
      last_row  = (row == ROW_IDX_WIDTH'(H_NUM_OF_ROWS - 1));
      for (int j = 0; j < W_NUM_OF_COLS; j++) begin
         product[j] = '0;
         if (col_ok) begin
            product[j] = PROD_WIDTH'(val_sel) * PROD_WIDTH'(weight_q[col_sel][j]);
         end
         acc_next[j] = acc[j] + WH_WIDTH'(product[j]);
      end
   end

   // Control FSM, input capture, accumulation and registered row outputs.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state        <= IDLE;
         row          <= '0;
         k            <= '0;
         wh_valid_o   <= 1'b0;
         wh_row_idx_o <= '0;
         row_info_o   <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         // NOTE: the capture arrays are plain flops, so clearing them on reset is cheap and keeps a fresh start deterministic.
         for (int j = 0; j < W_NUM_OF_COLS; j++) begin
            acc[j]       <= '0;
            wh_data_o[j] <= '0;
         end
         for (int i = 0; i < COL_INDEX_SIZE; i++) col_idx_q[i] <= '0;
         for (int i = 0; i < VALUE_SIZE; i++) value_q[i] <= '0;
         for (int i = 0; i < NODE_INFO_SIZE; i++) node_info_q[i] <= '0;
         for (int r = 0; r < W_NUM_OF_ROWS; r++) begin
            for (int j = 0; j < W_NUM_OF_COLS; j++) weight_q[r][j] <= '0;
         end
`ifdef GAT_PERF_CNT_EN
         cycle_cnt_o  <= '0;
`endif
      end else begin
         wh_valid_o <= 1'b0;
         done_o     <= 1'b0;
         case (state)
            IDLE: begin
               if (h_valid_i) begin
                  col_idx_q   <= col_idx_i;
                  value_q     <= value_i;
                  node_info_q <= node_info_i;
                  weight_q    <= weight_i;
                  busy_o      <= 1'b1;
                  row         <= '0;
                  k           <= '0;
                  for (int j = 0; j < W_NUM_OF_COLS; j++) acc[j] <= '0;
                  state       <= MAC;
`ifdef GAT_PERF_CNT_EN
                  cycle_cnt_o <= '0;
`endif
               end
            end
            MAC: begin
`ifdef GAT_PERF_CNT_EN
               if (cycle_cnt_o != 16'hFFFF) cycle_cnt_o <= cycle_cnt_o + 16'd1;
`endif
               if (last_elem) begin
                  wh_data_o    <= acc_next;
                  wh_valid_o   <= 1'b1;
                  wh_row_idx_o <= row;
                  row_info_o   <= {cur_len, cur_flag};
                  k            <= '0;
                  for (int j = 0; j < W_NUM_OF_COLS; j++) acc[j] <= '0;
                  if (last_row) begin
                     done_o <= 1'b1;
                     busy_o <= 1'b0;
                     state  <= FINISH;
                  end else begin
                     row <= row + ROW_IDX_WIDTH'(1);
                  end
               end else begin
                  acc <= acc_next;
                  k   <= k + ROW_LEN_WIDTH'(1);
               end
            end
            FINISH:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gat_feature_top.sv
// tb_gat_feature_top -- randomized self-checking bench for gat_feature_top.
// Expected rows and emit times come from an arithmetic sparse-times-dense
// reference model evaluated over the captured arrays.
// Build with GAT_PERF_CNT_EN defined to also check cycle_cnt_o.

module tb_gat_feature_top;

   localparam int NR = 5;   // nodes
   localparam int NC = 3;   // W columns
   localparam int NE = 8;   // col_idx / value depth
   localparam int NW = 5;   // W rows

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        h_valid = 1'b0;
   logic [2:0]  col_idx   [0:NE-1];
   logic [7:0]  value     [0:NE-1];
   logic [6:0]  node_info [0:NR-1];
   logic [7:0]  weight    [0:NW-1][0:NC-1];

   logic        wh_valid;
   logic [18:0] wh_data   [0:NC-1];
   logic [2:0]  wh_row_idx;
   logic [3:0]  row_info;
   logic        busy;
   logic        done;
`ifdef GAT_PERF_CNT_EN
   logic [15:0] cycle_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   int exp_data [0:NR-1][0:NC-1];
   int exp_off  [0:NR-1];
   int exp_info [0:NR-1];
   int exp_total;

   always #5 clk = ~clk;

   gat_feature_top dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .h_valid_i    (h_valid),
      .col_idx_i    (col_idx),
      .value_i      (value),
      .node_info_i  (node_info),
      .weight_i     (weight),
      .wh_valid_o   (wh_valid),
      .wh_data_o    (wh_data),
      .wh_row_idx_o (wh_row_idx),
      .row_info_o   (row_info),
      .busy_o       (busy),
      .done_o       (done)
`ifdef GAT_PERF_CNT_EN
      ,
      .cycle_cnt_o  (cycle_cnt)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Sparse row times dense W, straight from the CSR definition.
   function automatic void model();
      int t;
      t = 0;
      for (int n = 0; n < NR; n++) begin
         int ni, idx, len;
         ni  = int'(node_info[n]);
         idx = ni / 16;
         len = (ni / 2) % 8;
         exp_info[n] = ni % 16;
         for (int j = 0; j < NC; j++) begin
            int sum;
            sum = 0;
            for (int kk = 0; kk < len; kk++) begin
               int e, c;
               e = idx + kk;
               if (e < NE) begin
                  c = int'(col_idx[e]);
                  if (c < NW) sum += int'(value[e]) * int'(weight[c][j]);
               end
            end
            exp_data[n][j] = sum;
         end
         t += (len == 0) ? 1 : len;
         exp_off[n] = t;
      end
      exp_total = t;
   endfunction

   task automatic set_nominal();
      int c [0:NE-1] = '{0, 4, 2, 4, 1, 3, 2, 4};
      int v [0:NE-1] = '{2, 9, 7, 8, 6, 5, 3, 1};
      int ix[0:NR-1] = '{0, 2, 4, 6, 7};
      int ln[0:NR-1] = '{2, 2, 2, 1, 1};
      for (int i = 0; i < NE; i++) begin
         col_idx[i] = 3'(c[i]);
         value[i]   = 8'(v[i]);
      end
      for (int n = 0; n < NR; n++) node_info[n] = {3'(ix[n]), 3'(ln[n]), 1'b0};
      for (int r = 0; r < NW; r++)
         for (int j = 0; j < NC; j++) weight[r][j] = 8'(r + 1);
   endtask

   task automatic randomize_inputs();
      for (int i = 0; i < NE; i++) begin
         col_idx[i] = 3'($urandom_range(0, 7));
         value[i]   = 8'($urandom);
      end
      for (int n = 0; n < NR; n++)
         node_info[n] = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      for (int r = 0; r < NW; r++)
         for (int j = 0; j < NC; j++) weight[r][j] = 8'($urandom);
   endtask

   // Load the current arrays and follow the frame. glitch_at > 0 pulses
   // h_valid with fresh random arrays that many cycles after the load;
   // reset_after_row >= 0 asserts reset right after that row emits.
   task automatic run_frame(input int glitch_at, input int reset_after_row);
      int row;
      int valid_seen;
      model();
      @(negedge clk); h_valid = 1'b1;
      @(negedge clk); h_valid = 1'b0;
      check("busy_after_load", busy, 1);
      row = 0;
      for (int t = 1; t <= 60 && row < NR; t++) begin
         @(negedge clk);
         if (h_valid) h_valid = 1'b0;
         if (wh_valid) begin
            check($sformatf("row%0d_idx", row), wh_row_idx, row);
            check($sformatf("row%0d_time", row), t, exp_off[row]);
            check($sformatf("row%0d_info", row), row_info, exp_info[row]);
            check($sformatf("row%0d_done", row), done, (row == NR - 1) ? 1 : 0);
            for (int j = 0; j < NC; j++)
               check($sformatf("row%0d_data%0d", row, j), wh_data[j], exp_data[row][j]);
            if (row == reset_after_row) begin
               #2 rst_n = 1'b1;
               #1;
               check("rst_valid", wh_valid, 0);
               check("rst_busy", busy, 0);
               check("rst_row_idx", wh_row_idx, 0);
               check("rst_row_info", row_info, 0);
               check("rst_data0", wh_data[0], 0);
               @(negedge clk) rst_n = 1'b0;
               valid_seen = 0;
               repeat (20) @(negedge clk) if (wh_valid || done || busy) valid_seen++;
               check("quiet_after_reset", valid_seen, 0);
               return;
            end
            row++;
         end else begin
            check("no_done_mid_frame", done, 0);
         end
         if (t == glitch_at) begin
            randomize_inputs();
            h_valid = 1'b1;
         end
      end
      h_valid = 1'b0;
      if (row < NR) begin
         check("frame_timeout_rows", row, NR);
      end else begin
         check("busy_drop_at_done", busy, 0);
`ifdef GAT_PERF_CNT_EN
         check("cycle_cnt", cycle_cnt, exp_total);
`endif
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      set_nominal();
      // Reset held, then released with no load: everything stays quiet.
      repeat (2) @(negedge clk);
      check("reset_valid", wh_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_data", wh_data[0], 0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_valid", wh_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_info", row_info, 0);

      // Nominal frame, then outputs hold after the last row.
      set_nominal();
      run_frame(0, -1);
      @(negedge clk);
      check("hold_data", wh_data[1], exp_data[NR-1][1]);
      check("hold_idx", wh_row_idx, NR - 1);
      check("hold_valid_pulse", wh_valid, 0);
      check("hold_done_pulse", done, 0);

      // Zero-length node 2.
      set_nominal();
      node_info[2] = {3'd4, 3'd0, 1'b0};
      run_frame(0, -1);

      // Second load strobe mid-frame is ignored.
      set_nominal();
      run_frame(3, -1);

      // Reset after row 1, then a clean reload.
      set_nominal();
      run_frame(0, 1);
      set_nominal();
      run_frame(0, -1);

      // Back-to-back frames: random frames follow each done with no gap.
      for (int f = 0; f < 6; f++) begin
         randomize_inputs();
         run_frame((f == 2) ? 2 : 0, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
